// File: rtl/seq_det_param.sv
// Runtime-configurable serial sequence detector with a qualified bit stream,
// overlapping/non-overlapping modes and a saturating match counter.
module seq_det_param #(
   parameter int unsigned      PAT_W   = 8,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(8'h0B),
   parameter int unsigned      DEF_LEN = 4,
   parameter int unsigned      CNT_W   = 8,
   localparam int unsigned     LEN_W   = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             x_vld,
   input  logic             mode_ovl,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pat,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cnt_clr,
   output logic             detect,
   output logic             cfg_err,
   output logic [CNT_W-1:0] match_cnt
);

   logic [PAT_W-1:0] hist_q, hist_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [PAT_W-1:0] hist_sh;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] fill_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             detect_q, detect_d;
   logic             cfg_err_q, cfg_err_d;
   logic             hit;
   logic             len_ok;

   // Only the low len bits of history and pattern take part in the compare.
   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (LEN_W'(i) < len_q);
      end
   end

   always_comb begin
      hist_sh  = {hist_q[PAT_W-2:0], x};
      fill_inc = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);
      hit      = (fill_inc >= len_q) && ((hist_sh & mask) == (pat_q & mask));
      len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
   end

   always_comb begin
      hist_d    = hist_q;
      fill_d    = fill_q;
      pat_d     = pat_q;
      len_d     = len_q;
      detect_d  = 1'b0;
      cfg_err_d = 1'b0;
      cnt_d     = cnt_q;

      // A load strobe takes priority and discards any bit offered alongside it.
      if (cfg_load) begin
         if (len_ok) begin
            pat_d  = cfg_pat;
            len_d  = cfg_len;
            hist_d = '0;
            fill_d = '0;
         end else begin
            cfg_err_d = 1'b1;
         end
      end else if (x_vld) begin
         hist_d   = hist_sh;
         fill_d   = (hit && !mode_ovl) ? '0 : fill_inc;
         detect_d = hit;
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (detect_d && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q    <= '0;
         fill_q    <= '0;
         pat_q     <= DEF_PAT;
         len_q     <= LEN_W'(DEF_LEN);
         detect_q  <= 1'b0;
         cfg_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         detect_q  <= detect_d;
         cfg_err_q <= cfg_err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign detect    = detect_q;
   assign cfg_err   = cfg_err_q;
   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: expected detect values are queued as
// each bit is driven and compared after the sampling edge.
module tb_seq_det_param;

   localparam int unsigned PAT_W = 8;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned LEN_W = $clog2(PAT_W + 1);

   logic             clk;
   logic             rst;
   logic             x;
   logic             x_vld;
   logic             mode_ovl;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pat;
   logic [LEN_W-1:0] cfg_len;
   logic             cnt_clr;
   logic             detect;
   logic             cfg_err;
   logic [CNT_W-1:0] match_cnt;

   int unsigned n_vec;
   int unsigned n_err;
   logic        exp_q[$];

   seq_det_param #(
      .PAT_W  (PAT_W),
      .DEF_PAT(8'h0B),
      .DEF_LEN(4),
      .CNT_W  (CNT_W)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .x        (x),
      .x_vld    (x_vld),
      .mode_ovl (mode_ovl),
      .cfg_load (cfg_load),
      .cfg_pat  (cfg_pat),
      .cfg_len  (cfg_len),
      .cnt_clr  (cnt_clr),
      .detect   (detect),
      .cfg_err  (cfg_err),
      .match_cnt(match_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock with a bit offered; expected detect is queued, then popped after the edge.
   task automatic step(input logic xb, input logic vld, input logic clr, input logic exp_det,
                       input string tag);
      x       = xb;
      x_vld   = vld;
      cnt_clr = clr;
      exp_q.push_back(exp_det);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         check(tag, {31'd0, detect}, {31'd0, exp_q.pop_front()});
      end
      x_vld   = 1'b0;
      cnt_clr = 1'b0;
   endtask

   // Bits sent MSB first; exp bit i pairs with stream bit i.
   task automatic run_seq(input logic [31:0] bits, input logic [31:0] exp, input int n,
                          input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         step(bits[i], 1'b1, 1'b0, exp[i], tag);
      end
   endtask

   task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                       input logic vld, input logic xb, input logic exp_err, input string tag);
      cfg_load = 1'b1;
      cfg_pat  = pat;
      cfg_len  = len;
      x_vld    = vld;
      x        = xb;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      x_vld    = 1'b0;
      check({tag, "_err"}, {31'd0, cfg_err}, {31'd0, exp_err});
      check({tag, "_det"}, {31'd0, detect}, 32'd0);
   endtask

   task automatic clear_cnt();
      step(1'b0, 1'b0, 1'b1, 1'b0, "clr");
      check("clr_cnt", {30'd0, match_cnt}, 32'd0);
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b0;
      x        = 1'b0;
      x_vld    = 1'b0;
      mode_ovl = 1'b1;
      cfg_load = 1'b0;
      cfg_pat  = '0;
      cfg_len  = '0;
      cnt_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_det", {31'd0, detect}, 32'd0);
      check("rst_err", {31'd0, cfg_err}, 32'd0);
      check("rst_cnt", {30'd0, match_cnt}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // T1: overlapping, default 1011
      run_seq(32'b1011011, 32'b0001001, 7, "t1");
      check("t1_cnt", {30'd0, match_cnt}, 32'd2);
      clear_cnt();

      // T2: non-overlapping
      load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, "t2_load");
      mode_ovl = 1'b0;
      run_seq(32'b1011011, 32'b0001000, 7, "t2");
      check("t2_cnt", {30'd0, match_cnt}, 32'd1);
      clear_cnt();

      // T3: gap of invalid cycles with x toggling keeps the partial match
      mode_ovl = 1'b1;
      load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, "t3_load");
      run_seq(32'b101, 32'b000, 3, "t3_pre");
      step(1'b1, 1'b0, 1'b0, 1'b0, "t3_gap");
      step(1'b0, 1'b0, 1'b0, 1'b0, "t3_gap");
      step(1'b1, 1'b0, 1'b0, 1'b0, "t3_gap");
      step(1'b1, 1'b1, 1'b0, 1'b1, "t3_last");
      check("t3_cnt", {30'd0, match_cnt}, 32'd1);
      clear_cnt();

      // Load with a completing bit in the same cycle: bit dropped, history cleared
      run_seq(32'b101, 32'b000, 3, "ld_pre");
      load(8'h0B, 4'd4, 1'b1, 1'b1, 1'b0, "ld_x");
      step(1'b1, 1'b1, 1'b0, 1'b0, "ld_after");
      check("ld_cnt", {30'd0, match_cnt}, 32'd0);

      // T4: pattern 111, len 3
      load(8'h07, 4'd3, 1'b0, 1'b0, 1'b0, "t4_load");
      run_seq(32'b11111, 32'b00111, 5, "t4_ovl");
      check("t4_cnt_ovl", {30'd0, match_cnt}, 32'd3);
      clear_cnt();
      load(8'h07, 4'd3, 1'b0, 1'b0, 1'b0, "t4_reload");
      mode_ovl = 1'b0;
      run_seq(32'b11111, 32'b00100, 5, "t4_novl");
      check("t4_cnt_novl", {30'd0, match_cnt}, 32'd1);
      clear_cnt();

      // T5: illegal lengths rejected, default pattern retained
      mode_ovl = 1'b1;
      load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, "t5_def");
      load(8'hFF, 4'd0, 1'b0, 1'b0, 1'b1, "t5_len0");
      step(1'b0, 1'b0, 1'b0, 1'b0, "t5_gap");
      check("t5_err_low", {31'd0, cfg_err}, 32'd0);
      load(8'hFF, 4'(PAT_W + 1), 1'b0, 1'b0, 1'b1, "t5_len9");
      run_seq(32'b1011, 32'b0001, 4, "t5_seq");
      check("t5_cnt", {30'd0, match_cnt}, 32'd1);
      clear_cnt();

      // T6: reset mid-sequence discards partial history
      run_seq(32'b101, 32'b000, 3, "t6_pre");
      rst = 1'b0;
      #2;
      check("t6_rst_det", {31'd0, detect}, 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      step(1'b1, 1'b1, 1'b0, 1'b0, "t6_post");
      check("t6_cnt", {30'd0, match_cnt}, 32'd0);

      // Saturation: five hits on a 2-bit counter
      load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0, "sat_load");
      run_seq(32'b1011011011011011, 32'b0001001001001001, 16, "sat");
      check("sat_cnt", {30'd0, match_cnt}, 32'd3);

      // Clear coinciding with a hit: detect still pulses, count goes to zero
      run_seq(32'b01, 32'b00, 2, "clr_pre");
      step(1'b1, 1'b1, 1'b1, 1'b1, "clr_hit");
      check("clr_hit_cnt", {30'd0, match_cnt}, 32'd0);

      check("sb_drained", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
